// File: rtl/ahb_write_sizer.sv
// AHB-Lite write-path sizer: validates HSIZE/alignment, extracts active byte lanes and
// presents them right-aligned on a valid/ready port, converting back-pressure to wait states.
module ahb_write_sizer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic                            HSEL,
  input  logic [ADDR_W-1:0]               HADDR,
  input  logic [1:0]                      HTRANS,
  input  logic                            HWRITE,
  input  logic [2:0]                      HSIZE,
  input  logic                            HREADY,
  input  logic [DATA_W-1:0]               HWDATA,
  output logic                            HREADYOUT,
  output logic                            HRESP,
  output logic                            SVALID,
  input  logic                            SREADY,
  output logic [DATA_W-1:0]               SWDATA,
  output logic [DATA_W/8-1:0]             SBE,
  output logic [$clog2(DATA_W/8)-1:0]     SOFF,
  output logic [2:0]                      SSIZE,
  output logic [CNT_W-1:0]                ERR_CNT
);

  localparam int         NB       = DATA_W / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  typedef enum logic [2:0] {IDLE, DATA, STALL, ERR1, ERR2} state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    off_q;
  logic [2:0]          size_q;
  logic                svalid_q;
  logic [DATA_W-1:0]   swdata_q;
  logic [NB-1:0]       sbe_q;
  logic [OFF_W-1:0]    soff_q;
  logic [2:0]          ssize_q;
  logic [CNT_W-1:0]    err_cnt_q;

  logic                acc, bad, free, in_data, adv, load;
  logic [OFF_W-1:0]    align_mask;
  logic [NB-1:0]       lane_mask;
  logic [DATA_W-1:0]   data_mask;
  int                  nbytes;

  logic unused_haddr;
  assign unused_haddr = ^HADDR[ADDR_W-1:OFF_W];

  always_comb begin
    acc        = HSEL & HREADY & HTRANS[1];
    align_mask = OFF_W'((32'd1 << HSIZE) - 32'd1);
    bad        = (HSIZE > MAX_SIZE) | ((HADDR[OFF_W-1:0] & align_mask) != '0);
    state_d    = !acc ? IDLE : bad ? ERR1 : HWRITE ? DATA : IDLE;
    free       = !svalid_q | SREADY;
    in_data    = (state_q == DATA) | (state_q == STALL);
    load       = in_data & free;
    // adv: the current transfer completes this cycle, so a new address phase may be taken
    adv        = (state_q != ERR1) & (!in_data | free);
    HREADYOUT  = in_data ? free : (state_q != ERR1);
    HRESP      = (state_q == ERR1) | (state_q == ERR2);
    nbytes     = 1 << size_q;
    lane_mask  = '0;
    data_mask  = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i]       = (i < nbytes);
      data_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= IDLE;
      off_q     <= '0;
      size_q    <= '0;
      svalid_q  <= 1'b0;
      swdata_q  <= '0;
      sbe_q     <= '0;
      soff_q    <= '0;
      ssize_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (adv)                    state_q <= state_d;
      else if (state_q == ERR1)   state_q <= ERR2;
      else                        state_q <= STALL;

      if (adv & acc) begin
        off_q  <= HADDR[OFF_W-1:0];
        size_q <= HSIZE;
        if (bad & ~&err_cnt_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end

      if (load) begin
        swdata_q <= (HWDATA >> {off_q, 3'b000}) & data_mask;
        sbe_q    <= lane_mask << off_q;
        soff_q   <= off_q;
        ssize_q  <= size_q;
        svalid_q <= 1'b1;
      end else if (SREADY) begin
        svalid_q <= 1'b0;
      end
    end
  end

  assign SVALID  = svalid_q;
  assign SWDATA  = swdata_q;
  assign SBE     = sbe_q;
  assign SOFF    = soff_q;
  assign SSIZE   = ssize_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_write_sizer.sv
// Directed bench for ahb_write_sizer with a beat scoreboard on the back-end port.
module tb_ahb_write_sizer;

  logic         HCLK = 1'b0;
  logic         HRESET, HSEL, HWRITE, HREADY, SREADY;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [127:0] HWDATA;
  logic         HREADYOUT, HRESP, SVALID;
  logic [127:0] SWDATA;
  logic [15:0]  SBE;
  logic [3:0]   SOFF;
  logic [2:0]   SSIZE;
  logic [7:0]   ERR_CNT;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  be;
    logic [3:0]   off;
    logic [2:0]   sz;
  } beat_t;

  beat_t        q[$];
  int           checks = 0, passes = 0, fails = 0, delivered = 0;
  logic [127:0] w;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_write_sizer #(.DATA_W(128), .ADDR_W(32), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .SVALID(SVALID), .SREADY(SREADY),
    .SWDATA(SWDATA), .SBE(SBE), .SOFF(SOFF), .SSIZE(SSIZE), .ERR_CNT(ERR_CNT)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [127:0] d, input int off, input int sz);
    beat_t b;
    b.d  = '0;
    b.be = '0;
    for (int k = 0; k < (1 << sz); k++) begin
      b.d[8*k +: 8] = d[8*(off+k) +: 8];
      b.be[off+k]   = 1'b1;
    end
    b.off = 4'(off);
    b.sz  = 3'(sz);
    return b;
  endfunction

  task automatic nxt;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic addr(input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
  endtask

  task automatic noaddr;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_hreadyout"}, HREADYOUT, 1);
    chk({pfx, "_hresp"},     HRESP, 0);
    chk({pfx, "_svalid"},    SVALID, 0);
    chk({pfx, "_swdata"},    SWDATA, 0);
    chk({pfx, "_sbe"},       SBE, 0);
    chk({pfx, "_soff"},      SOFF, 0);
    chk({pfx, "_ssize"},     SSIZE, 0);
    chk({pfx, "_errcnt"},    ERR_CNT, 0);
  endtask

  always @(negedge HCLK) begin : mon
    beat_t b;
    if (!HRESET && SVALID && SREADY) begin
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = q.pop_front();
        chk("sb_swdata", SWDATA, b.d);
        chk("sb_sbe",    SBE,    b.be);
        chk("sb_soff",   SOFF,   b.off);
        chk("sb_ssize",  SSIZE,  b.sz);
        delivered++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; SREADY = 1'b1; HADDR = '0; HSIZE = '0; HWDATA = '0;
    noaddr();
    nxt(); nxt();
    HRESET = 1'b0;
    settle();
    chk_reset_vals("rst");

    // byte write at offset 5
    nxt(); addr(32'h5, 3'b000); settle();
    chk("t1_ready_addr", HREADYOUT, 1);
    nxt(); noaddr();
    w = {$urandom, $urandom, $urandom, $urandom}; w[47:40] = 8'hA5; HWDATA = w;
    q.push_back(mk(w, 5, 0));
    settle();
    chk("t1_ready_data", HREADYOUT, 1);
    chk("t1_resp_data", HRESP, 0);
    nxt(); settle();
    chk("t1_svalid", SVALID, 1);
    chk("t1_swdata", SWDATA, 128'hA5);
    chk("t1_sbe", SBE, 16'h0020);
    chk("t1_soff", SOFF, 5);
    nxt(); settle();
    chk("t1_svalid_clr", SVALID, 0);

    // misaligned word
    addr(32'h6, 3'b010);
    nxt(); noaddr(); settle();
    chk("t2_err1_ready", HREADYOUT, 0);
    chk("t2_err1_resp", HRESP, 1);
    chk("t2_err1_svalid", SVALID, 0);
    nxt(); settle();
    chk("t2_err2_ready", HREADYOUT, 1);
    chk("t2_err2_resp", HRESP, 1);
    chk("t2_errcnt", ERR_CNT, 1);
    chk("t2_err2_svalid", SVALID, 0);
    nxt(); settle();
    chk("t2_okay_after", HRESP, 0);
    chk("t2_swdata_kept", SWDATA, 128'hA5);
    chk("t2_sbe_kept", SBE, 16'h0020);

    // oversize, then a word write accepted during ERR2
    addr(32'h0, 3'b101);
    nxt(); noaddr(); settle();
    chk("t3_err1_ready", HREADYOUT, 0);
    chk("t3_err1_resp", HRESP, 1);
    nxt(); addr(32'h8, 3'b010); settle();
    chk("t3_err2_ready", HREADYOUT, 1);
    chk("t3_err2_resp", HRESP, 1);
    chk("t3_errcnt", ERR_CNT, 2);
    nxt(); noaddr();
    w = {$urandom, $urandom, $urandom, $urandom}; w[95:64] = 32'hCAFEF00D; HWDATA = w;
    q.push_back(mk(w, 8, 2));
    settle();
    chk("t3_data_ready", HREADYOUT, 1);
    chk("t3_data_resp", HRESP, 0);
    nxt(); settle();
    chk("t3_svalid", SVALID, 1);
    chk("t3_swdata", SWDATA, 128'hCAFEF00D);
    chk("t3_sbe", SBE, 16'h0F00);
    chk("t3_soff", SOFF, 8);
    chk("t3_ssize", SSIZE, 2);
    nxt();

    // back-pressure with three back-to-back word writes
    SREADY = 1'b0;
    addr(32'h0, 3'b010);
    nxt(); addr(32'h4, 3'b010);
    w = {$urandom, $urandom, $urandom, $urandom}; w[31:0] = 32'h11111111; HWDATA = w;
    q.push_back(mk(w, 0, 2));
    settle();
    chk("t4_dp1_ready", HREADYOUT, 1);
    nxt(); addr(32'h8, 3'b010);
    w = {$urandom, $urandom, $urandom, $urandom}; w[63:32] = 32'h22222222; HWDATA = w;
    q.push_back(mk(w, 4, 2));
    settle();
    chk("t4_dp2_ready", HREADYOUT, 0);
    chk("t4_dp2_svalid", SVALID, 1);
    for (int c = 0; c < 2; c++) begin
      nxt(); settle();
      chk("t4_stall_ready", HREADYOUT, 0);
      chk("t4_stall_hold", SWDATA, 128'h11111111);
    end
    nxt(); SREADY = 1'b1; settle();
    chk("t4_release_ready", HREADYOUT, 1);
    nxt(); noaddr();
    w = {$urandom, $urandom, $urandom, $urandom}; w[95:64] = 32'h33333333; HWDATA = w;
    q.push_back(mk(w, 8, 2));
    settle();
    chk("t4_beat2", SWDATA, 128'h22222222);
    chk("t4_dp3_ready", HREADYOUT, 1);
    nxt(); settle();
    chk("t4_beat3", SWDATA, 128'h33333333);
    nxt(); settle();
    chk("t4_drained", SVALID, 0);
    chk("t4_queue_empty", q.size(), 0);
    chk("t4_delivered", delivered, 5);

    // reset while stalled
    SREADY = 1'b0;
    addr(32'h0, 3'b010);
    nxt(); addr(32'h4, 3'b010);
    w = {$urandom, $urandom, $urandom, $urandom}; HWDATA = w;
    q.push_back(mk(w, 0, 2));
    nxt(); noaddr();
    q.push_back(mk(w, 4, 2));
    settle();
    chk("t5_stall_ready", HREADYOUT, 0);
    nxt();
    HRESET = 1'b1;
    q.delete();
    nxt();
    HRESET = 1'b0; SREADY = 1'b1;
    settle();
    chk_reset_vals("t5");
    for (int c = 0; c < 3; c++) begin
      nxt(); settle();
      chk("t5_no_beat", SVALID, 0);
    end

    // full-width write, then BUSY cycles
    addr(32'h10, 3'b100);
    nxt();
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1;
    w = {$urandom, $urandom, $urandom, $urandom}; HWDATA = w;
    q.push_back(mk(w, 0, 4));
    settle();
    chk("t6_data_ready", HREADYOUT, 1);
    nxt(); settle();
    chk("t6_svalid", SVALID, 1);
    chk("t6_swdata", SWDATA, w);
    chk("t6_sbe", SBE, 16'hFFFF);
    nxt(); settle();
    chk("t6_busy_ready", HREADYOUT, 1);
    chk("t6_busy_resp", HRESP, 0);
    chk("t6_busy_svalid", SVALID, 0);
    noaddr();
    nxt(); nxt(); settle();
    chk("end_queue_empty", q.size(), 0);
    chk("end_delivered", delivered, 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
